// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DBIT data bits LSB-first, stop period.
// Bit timing is counted in s_tick pulses from the shared baud generator.
module uart_tx #(
    parameter int unsigned DBIT      = 8,
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned SB_TICK   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int unsigned S_MAX = (BIT_WIDTH > SB_TICK) ? BIT_WIDTH : SB_TICK;
    localparam int unsigned S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
    localparam int unsigned N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [S_W-1:0]  s_cnt;
    logic [S_W-1:0]  s_next;
    logic [N_W-1:0]  n_cnt;
    logic [N_W-1:0]  n_next;
    logic [DBIT-1:0] b_reg;
    logic [DBIT-1:0] b_next;
    logic            tx_next;
    logic            done_next;

    logic bit_end;
    logic stop_end;

    assign bit_end  = (s_cnt == S_W'(BIT_WIDTH - 1));
    assign stop_end = (s_cnt == S_W'(SB_TICK - 1));

    // State and datapath registers; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            s_cnt   <= '0;
            n_cnt   <= '0;
            b_reg   <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_next;
            s_cnt   <= s_next;
            n_cnt   <= n_next;
            b_reg   <= b_next;
            tx      <= tx_next;
            tx_done <= done_next;
        end
    end

    // Next-state and datapath decode; everything holds between ticks
    always_comb begin
        state_next = state;
        s_next     = s_cnt;
        n_next     = n_cnt;
        b_next     = b_reg;
        case (state)
            IDLE: begin
                if (tx_start) begin
                    b_next     = tx_din;
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (bit_end) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s_cnt + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (bit_end) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_cnt == N_W'(DBIT - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_cnt + N_W'(1);
                        end
                    end else begin
                        s_next = s_cnt + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (stop_end) begin
                        s_next     = '0;
                        state_next = IDLE;
                    end else begin
                        s_next = s_cnt + S_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level follows the next state so tx always matches the current state
    always_comb begin
        tx_next   = 1'b1;
        done_next = s_tick && (state == STOP) && stop_end;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx_busy = (state != IDLE);

endmodule
